// File: rtl/seg7_decode_if.sv
// Consumer-facing bundle for seg7_decode: raw segment input plus the decoded-digit
// valid/ready output channel and the illegal-pattern counter.
interface seg7_decode_if;
  logic [1:7] leds;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] x;
  logic       err;
  logic [7:0] err_count;

  modport master (
    output leds,
    output out_ready,
    input  out_valid,
    input  x,
    input  err,
    input  err_count
  );

  modport slave (
    input  leds,
    input  out_ready,
    output out_valid,
    output x,
    output err,
    output err_count
  );
endinterface

// File: rtl/seg7_decode.sv
// Debounced seven-segment (active-low, abcdefg) to hex decoder with a valid/ready
// output; each stable new pattern is presented once, illegal ones flagged and counted.
module seg7_decode #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clock,
  input  logic          reset,
  seg7_decode_if.slave  bus
);

  localparam logic [1:7] BLANK    = 7'b1111111;
  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  typedef enum logic {SETTLE, EMIT} state_t;

  state_t     state_q, state_d;
  logic [1:7] samp_q, samp_d;
  logic [1:7] cand_q, cand_d;
  logic [1:7] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] err_count_q, err_count_d;
  logic [3:0] x_q, x_d;
  logic       err_q, err_d;

  // Returns {illegal, hex}; illegal patterns (blank included) decode to hex 0.
  function automatic logic [4:0] decode(input logic [1:7] p);
    case (p)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b1100000: decode = 5'h0B;
      7'b0110001: decode = 5'h0C;
      7'b1000010: decode = 5'h0D;
      7'b0110000: decode = 5'h0E;
      7'b0111000: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    samp_d      = bus.leds;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    err_count_d = err_count_q;
    x_d         = x_q;
    err_d       = err_q;

    case (state_q)
      SETTLE: begin
        if (samp_q != cand_q) begin
          cand_d = samp_q;
          cnt_d  = 8'd1;
        end else begin
          if (cnt_q < STABLE_N) cnt_d = cnt_q + 8'd1;
          // Candidate has been seen STABLE_CYCLES+1 times in a row: accept it.
          if (cnt_q == STABLE_N) begin
            if (cand_q == BLANK) begin
              last_d = BLANK;
            end else if (cand_q != last_q) begin
              state_d      = EMIT;
              {err_d, x_d} = decode(cand_q);
            end
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          state_d = SETTLE;
          last_d  = cand_q;
          cnt_d   = 8'd0;
          if (err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SETTLE;
      samp_q      <= BLANK;
      cand_q      <= BLANK;
      last_q      <= BLANK;
      cnt_q       <= 8'd0;
      err_count_q <= 8'd0;
      x_q         <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      cand_q      <= cand_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
      x_q         <= x_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid = (state_q == EMIT);
  assign bus.x         = x_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_seg7_decode.sv
// Directed bench for seg7_decode: a run-length reference model checked every cycle,
// plus literal checks on latency, glitch rejection, repeats, errors and reset.
module tb_seg7_decode;

  localparam int         S     = 4;
  localparam logic [1:7] BLANK = 7'b1111111;

  logic clock = 1'b0;
  logic reset = 1'b1;
  seg7_decode_if bus();

  seg7_decode #(.STABLE_CYCLES(S)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [1:7] legal_pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_digit(input logic [1:7] p);
    for (int i = 0; i < 16; i++) if (legal_pat[i] == p) return i;
    return -1;
  endfunction

  // Reference model: a pattern is accepted once the same registered sample has been
  // seen on S+1 consecutive settling edges since the last restart (reset or handshake).
  logic [1:7] m_prev = BLANK, m_runval = BLANK, m_last = BLANK, m_pat = BLANK;
  int         m_run = 0, m_errc = 0;
  logic       m_valid = 1'b0, m_err = 1'b0, m_rst = 1'b1;
  logic [3:0] m_x = 4'd0;

  task automatic model_step();
    logic [1:7] s;
    int d;
    if (reset) begin
      m_valid = 1'b0; m_x = 4'd0; m_err = 1'b0; m_errc = 0;
      m_last = BLANK; m_prev = BLANK; m_runval = BLANK; m_run = 0; m_rst = 1'b1;
    end else begin
      m_rst  = 1'b0;
      s      = m_prev;
      m_prev = bus.leds;
      if (m_valid) begin
        if (bus.out_ready) begin
          m_last  = m_pat;
          if (m_err && m_errc < 255) m_errc++;
          m_valid = 1'b0;
          m_run   = 0;
        end
      end else begin
        if (m_run != 0 && s == m_runval) m_run++;
        else begin
          m_runval = s;
          m_run    = 1;
        end
        if (m_run >= S + 1) begin
          if (s == BLANK) m_last = BLANK;
          else if (s != m_last) begin
            m_valid = 1'b1;
            m_pat   = s;
            d       = find_digit(s);
            m_err   = (d < 0);
            m_x     = (d < 0) ? 4'd0 : 4'(d);
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Handshake monitor (reset edges never count as a handshake).
  int hs_cnt = 0;
  int err_emits = 0;
  int emit_x [16];
  initial begin
    for (int i = 0; i < 16; i++) emit_x[i] = 0;
    forever begin
      @(posedge clock);
      if (!reset && bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (bus.err) err_emits++;
        else emit_x[bus.x]++;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clock);
    chk("model_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("model_err_count", 32'(bus.err_count), 32'(m_errc));
    if (m_valid || m_rst) begin
      chk("model_x", 32'(bus.x), 32'(m_x));
      chk("model_err", 32'(bus.err), 32'(m_err));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL %s timeout actual=out_valid=0 required=out_valid=1", name);
    end
  endtask

  initial begin
    int base_a, base_1, base_3, hs0;
    bus.leds      = BLANK;
    bus.out_ready = 1'b1;
    step(2);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);

    // Latency and single pulse for digit 2.
    reset    = 1'b0;
    bus.leds = 7'b0010010;
    for (int k = 0; k <= S; k++) begin
      @(negedge clock);
      chk("t1_early_valid", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clock);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_x", 32'(bus.x), 32'd2);
    chk("t1_err", 32'(bus.err), 32'd0);
    @(negedge clock);
    chk("t1_pulse_end", 32'(bus.out_valid), 32'd0);
    step(20);
    chk("t1_once", 32'(emit_x[2]), 32'd1);

    // Glitch of 1 for three cycles, then 3 held.
    base_1 = emit_x[1];
    base_3 = emit_x[3];
    bus.leds = 7'b1001111;
    step(3);
    bus.leds = 7'b0000110;
    step(15);
    chk("t2_no_1", 32'(emit_x[1] - base_1), 32'd0);
    chk("t2_one_3", 32'(emit_x[3] - base_3), 32'd1);

    // A, blank for 6 cycles, A again.
    base_a = emit_x[10];
    bus.leds = 7'b0001000;
    step(10);
    bus.leds = BLANK;
    step(6);
    bus.leds = 7'b0001000;
    step(12);
    chk("t3_two_a", 32'(emit_x[10] - base_a), 32'd2);

    // Illegal pattern and error counter saturation.
    bus.out_ready = 1'b0;
    bus.leds = 7'b1010101;
    wait_valid("t4_wait");
    chk("t4_x", 32'(bus.x), 32'd0);
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_count_before", 32'(bus.err_count), 32'd0);
    bus.out_ready = 1'b1;
    step(1);
    chk("t4_count_one", 32'(bus.err_count), 32'd1);
    chk("t4_valid_drop", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 299; i++) begin
      bus.leds = (i % 2 == 0) ? 7'b0101010 : 7'b1010101;
      step(8);
    end
    chk("t4_count_sat", 32'(bus.err_count), 32'd255);
    chk("t4_err_emits", 32'(err_emits), 32'd300);

    // Backpressure with leds toggling during EMIT.
    bus.out_ready = 1'b0;
    bus.leds = 7'b0000000;
    wait_valid("t5_wait");
    for (int i = 0; i < 10; i++) begin
      bus.leds = (i % 2 == 0) ? 7'b1001111 : 7'b0010010;
      @(negedge clock);
      chk("t5_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t5_hold_x", 32'(bus.x), 32'd8);
      chk("t5_hold_err", 32'(bus.err), 32'd0);
    end
    bus.leds = 7'b0110001;
    step(2);
    chk("t5_still_x", 32'(bus.x), 32'd8);
    hs0 = hs_cnt;
    bus.out_ready = 1'b1;
    for (int k = 0; k <= S; k++) begin
      @(negedge clock);
      chk("t5_gap_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("t5_one_hs", 32'(hs_cnt - hs0), 32'd1);
    @(negedge clock);
    chk("t5_new_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_new_x", 32'(bus.x), 32'd12);
    step(3);

    // Reset while presenting an illegal pattern with ready raised in the same cycle.
    bus.out_ready = 1'b0;
    bus.leds = 7'b1010101;
    wait_valid("t6_wait");
    hs0 = hs_cnt;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_err_count", 32'(bus.err_count), 32'd0);
    chk("t6_x", 32'(bus.x), 32'd0);
    chk("t6_no_hs", 32'(hs_cnt - hs0), 32'd0);
    reset = 1'b0;
    step(10);
    chk("t6_reemit_count", 32'(bus.err_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_decode.md
SEG7_DECODE -- requirements
Module: seg7_decode

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, is the number of consecutive identical samples required before a pattern is accepted; legal range 1..255.
REQ-002 Port: clock  input  1  is the sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  is a synchronous, active-high reset.
REQ-004 Port: leds  input  [1:7]  is the active-low segment pattern; bit 1=a ... bit 7=g (abcdefg order).
REQ-005 Port: out_ready  input  1  is the consumer ready signal.
REQ-006 Port: out_valid  output  1  indicates a decoded digit is presented.
REQ-007 Port: x  output  [3:0]  is the decoded hex value.
REQ-008 Port: err  output  1  marks the presented pattern as not a legal digit.
REQ-009 Port: err_count  output  [7:0]  counts emitted illegal patterns.

Function
REQ-010 Decode table (leds[1:7] -> x), which SHALL be exact:
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111,
  8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-011 Blank pattern 1111111 SHALL mean "no digit": never emitted; when accepted, it sets last_emitted to blank.
REQ-012 Any other pattern is illegal; when emitted, it SHALL present x=0 and err=1.
REQ-013 Input stage: samp SHALL register leds every cycle (one-stage sampling); all decisions use samp only.
REQ-014 Candidate tracking in SETTLE:
  - samp != cand: cand<=samp, cnt<=1.
  - otherwise: cnt increments, saturating at STABLE_CYCLES.
REQ-015 FSM states: SETTLE and EMIT only.
REQ-016 SETTLE -> EMIT on the edge where cnt==STABLE_CYCLES and samp==cand and cand is neither blank nor equal to last_emitted.
REQ-017 SETTLE, accepted blank: when cnt==STABLE_CYCLES and cand is blank, last_emitted<=blank and the FSM stays in SETTLE.
REQ-018 SETTLE, duplicate: an accepted cand equal to last_emitted SHALL NOT re-emit.
REQ-019 Latency: a pattern stable at leds from just before edge n SHALL raise out_valid after edge n+STABLE_CYCLES+1 (STABLE_CYCLES+2 edges counting edge n).
REQ-020 EMIT behaviour:
  - out_valid=1; x and err are held constant and derived from cand.
  - cand and cnt are frozen; leds changes are ignored.
REQ-021 Handshake: on an edge with out_valid && out_ready:
  - last_emitted<=cand, cnt<=0, state<=SETTLE;
  - err_count increments if err=1, saturating at 255.
  - out_valid SHALL be 0 in the following cycle.
REQ-022 out_ready while out_valid=0 SHALL be ignored; out_valid SHALL NOT drop without a handshake except on reset.
REQ-023 A digit, then blank, then the same digit SHALL emit that digit twice; a digit held indefinitely SHALL emit exactly once.
REQ-024 Changing leds during EMIT to a new stable pattern SHALL be evaluated only after the handshake, restarting the count from samp at that time.

Reset
REQ-025 On reset the block SHALL set:
  - state=SETTLE;
  - samp=cand=last_emitted=1111111, cnt=0;
  - out_valid=0, x=0, err=0, err_count=0.
REQ-026 Reset SHALL override all other events in the same cycle, including a handshake.
REQ-027 Reset in EMIT SHALL discard the pending digit without updating err_count.
REQ-028 After reset, outputs SHALL equal reset values from the first edge with reset high.

Verification
REQ-029 STABLE_CYCLES=4, out_ready=1; leds=0010010 held from edge 0 -> out_valid=1 after edge 5, x=2, err=0; single one-cycle pulse; no re-emission while held.
REQ-030 Glitch: leds=1001111 for 3 cycles then 0000110 held -> no emission of 1; emits x=3 exactly once.
REQ-031 Repeat: 0001000, then blank for 6 cycles, then 0001000 again -> two emissions, x=A both times.
REQ-032 Illegal: leds=1010101 held -> out_valid=1, x=0, err=1; after handshake err_count=1; 300 separate illegal emissions -> err_count=255.
REQ-033 Backpressure: out_ready=0 during EMIT for 10 cycles while leds toggles -> x/err stable, out_valid held; out_ready=1 -> one handshake, then the new stable pattern emits after STABLE_CYCLES+1 further edges.
REQ-034 Reset mid-EMIT with out_ready=1 in the same cycle -> out_valid=0, err_count=0 next cycle, no handshake recorded.
